lsu_mem_initiator: RTL and testbench

// - Processor-side initiator for the data-memory load/store port; sits between the core's MEM stage and the data memory.
// - Accepts one load/store, decodes funct3 into the 4-bit sign_mask, checks alignment, drives the memory for its two-phase access, stalls the core, and returns load data.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/mem_sign_mask_gen.sv | 47 ++++
 rtl/lsu_mem_initiator.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the data-memory load/store initiator.
// - FSM state encoding for lsu_mem_initiator.
// - RV32I load/store funct3 codes.
// - Size field values for the 4-bit sign_mask ([3] signed, [2:0] size).
// - MMIO_LED_ADDR: address of the board LED register (reference only).
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } lsu_state_e;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // sign_mask[2:0] size field
    localparam logic [2:0] SIZE_BYTE = 3'b001;
    localparam logic [2:0] SIZE_HALF = 3'b011;
    localparam logic [2:0] SIZE_WORD = 3'b111;

    localparam logic [31:0] MMIO_LED_ADDR = 32'h0000_2000;

endpackage

// File: rtl/mem_sign_mask_gen.sv
// mem_sign_mask_gen: combinational decode of a load/store request.
// Ports:
//   funct3_i      RV32I funct3 of the request
//   write_i       1 = store, 0 = load
//   addr_lo_i     effective address bits [1:0]
//   sign_mask_o   {signed, size[2:0]} for the data memory
//   illegal_o     funct3 does not name a legal load/store
//   misaligned_o  half not 2-byte aligned, or word not 4-byte aligned
module mem_sign_mask_gen
    import lsu_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       write_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] sign_mask_o,
    output logic       illegal_o,
    output logic       misaligned_o
);

    logic [2:0] size;
    logic       bad_size;

    always_comb begin
        size         = 3'b000;
        bad_size     = 1'b0;
        misaligned_o = 1'b0;
        unique case (funct3_i[1:0])
            2'b00: size = SIZE_BYTE;
            2'b01: begin
                size         = SIZE_HALF;
                misaligned_o = addr_lo_i[0];
            end
            2'b10: begin
                size         = SIZE_WORD;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: bad_size = 1'b1;
        endcase
    end

    // Unsigned variants exist only for loads, and there is no unsigned word load.
    assign illegal_o   = bad_size
                       | ( write_i & funct3_i[2])
                       | (!write_i & (funct3_i == 3'b110));
    assign sign_mask_o = {~funct3_i[2], size};

endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: processor-side initiator for the data-memory port.
// Accepts one load/store from the MEM stage, checks it, holds the memory
// strobes for ACCESS_PHASES cycles, then pulses resp_valid for one cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/write/funct3/addr/wdata   request from the core (sampled in IDLE only)
//   stall                    hold the core pipeline
//   resp_valid/rdata/fault   completion pulse, load data (held), fault flag
//   mem_addr/write_data/memwrite/memread/sign_mask   data-memory request
//   mem_read_data            registered read data from data memory
// FSM state is the internal signal state_q (lsu_state_e).
//
// Handshake: the core raises req_valid with a stable request; stall is high
// from the request cycle until the response cycle, in which resp_valid pulses
// with stall low, so the core advances exactly when resp_valid is seen.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int CHECK_ALIGN   = 1,
    parameter int ACCESS_PHASES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] LAST_PHASE = 3'(ACCESS_PHASES);

    lsu_state_e  state_q, state_d;
    logic [2:0]  phase_cnt_q, phase_cnt_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  mask_q;
    logic        write_q;

    logic [3:0]  dec_mask;
    logic        dec_illegal, dec_misaligned, req_fault;
    logic        latch_req;

    mem_sign_mask_gen u_mask_gen (
        .funct3_i     (req_funct3),
        .write_i      (req_write),
        .addr_lo_i    (req_addr[1:0]),
        .sign_mask_o  (dec_mask),
        .illegal_o    (dec_illegal),
        .misaligned_o (dec_misaligned)
    );

    assign req_fault = dec_illegal | ((CHECK_ALIGN != 0) & dec_misaligned);

    always_comb begin
        state_d      = state_q;
        phase_cnt_d  = phase_cnt_q;
        stall        = 1'b0;
        resp_valid   = 1'b0;
        resp_fault   = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        latch_req    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    latch_req = 1'b1;
                    if (req_fault) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d     = ST_PHASE;
                        phase_cnt_d = 3'd1;
                    end
                end
            end
            ST_PHASE: begin
                stall        = 1'b1;
                mem_memread  = !write_q;
                mem_memwrite = write_q;
                if (phase_cnt_q == LAST_PHASE) begin
                    state_d = ST_RESP;
                end else begin
                    phase_cnt_d = phase_cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FAULT: begin
                resp_valid = 1'b1;
                resp_fault = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_cnt_q <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            mask_q      <= 4'b0000;
            write_q     <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            if (latch_req) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                mask_q  <= dec_mask;
                write_q <= req_write;
            end
            if (state_q == ST_RESP && !write_q) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    // Load data is forwarded straight from memory in the response cycle and
    // held afterwards; stores leave the previous load value visible.
    assign resp_rdata     = (state_q == ST_RESP && !write_q) ? mem_read_data : rdata_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_sign_mask  = mask_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    localparam int PH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        stall, resp_valid, resp_fault, mem_memwrite, mem_memread;
    logic [31:0] resp_rdata, mem_addr, mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = 32'd0;

    lsu_mem_initiator #(.CHECK_ALIGN(1), .ACCESS_PHASES(PH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- data memory environment ----------------
    logic [31:0] bmem [1024];
    logic [7:0]  led_q = 8'd0;
    always @(posedge clk) begin
        if (mem_memread) mem_read_data <= bmem[mem_addr[11:2]];
        else             mem_read_data <= $urandom;   // garbage when not reading
        if (mem_memwrite) begin
            bmem[mem_addr[11:2]] <= mem_write_data;
            if (mem_addr == 32'h0000_2000) led_q <= mem_write_data[7:0];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode as a lookup table of the legal RV32I load/store encodings.
    task automatic m_decode(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            output logic [3:0] mask, output logic fault);
        logic ok_align;
        mask = 4'b0000; fault = 1'b0; ok_align = 1'b1;
        case ({w, f3})
            4'b0_000: mask = 4'b1001;
            4'b0_100: mask = 4'b0001;
            4'b1_000: mask = 4'b1001;
            4'b0_001, 4'b1_001: begin mask = 4'b1011; ok_align = (a % 2 == 0); end
            4'b0_101:           begin mask = 4'b0011; ok_align = (a % 2 == 0); end
            4'b0_010, 4'b1_010: begin mask = 4'b1111; ok_align = (a % 4 == 0); end
            default: fault = 1'b1;
        endcase
        if (!ok_align) fault = 1'b1;
    endtask

    // Model: an accepted op occupies cycles 1..PH with strobes and PH+1 with
    // the response (faults: response in cycle 1); m_off counts cycles since accept.
    logic [31:0] mmem [1024];
    logic        check_en = 1'b0;
    logic        m_active = 1'b0, m_fault = 1'b0, m_write = 1'b0, m_after_rst = 1'b1;
    int          m_off = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_data = 0, m_hold = 0;
    logic [3:0]  m_mask = 0;
    logic        e_stall, e_rv, e_f, e_rd, e_wr;

    int rd_cnt = 0, wr_cnt = 0, rv_cnt = 0, stall_cnt = 0, last_resp_cyc = 0;
    logic [31:0] last_rdata = 0;
    logic        last_fault = 0;
    logic [3:0]  last_mask = 0;

    always @(negedge clk) begin
        if (check_en) begin
            e_stall = 0; e_rv = 0; e_f = 0; e_rd = 0; e_wr = 0;
            if (!m_active) e_stall = req_valid;
            else if (m_fault) begin e_rv = 1; e_f = 1; end
            else if (m_off <= PH) begin e_stall = 1; e_rd = !m_write; e_wr = m_write; end
            else begin
                e_rv = 1;
                if (!m_write) m_hold = m_data;
            end
            chk("stall", 32'(stall), 32'(e_stall));
            chk("resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("resp_fault", 32'(resp_fault), 32'(e_f));
            chk("mem_memread", 32'(mem_memread), 32'(e_rd));
            chk("mem_memwrite", 32'(mem_memwrite), 32'(e_wr));
            chk("resp_rdata", resp_rdata, m_hold);
            if (e_rd || e_wr || m_after_rst) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_write_data", mem_write_data, m_wdata);
                chk("mem_sign_mask", 32'(mem_sign_mask), 32'(m_mask));
            end
            if (mem_memread)  begin rd_cnt++; last_mask = mem_sign_mask; end
            if (mem_memwrite) begin wr_cnt++; last_mask = mem_sign_mask; end
            if (stall) stall_cnt++;
            if (resp_valid) begin
                rv_cnt++; last_resp_cyc = cyc; last_rdata = resp_rdata; last_fault = resp_fault;
            end
            // advance to the next cycle
            if (rst) begin
                m_active = 0; m_hold = 0; m_addr = 0; m_wdata = 0; m_mask = 0; m_after_rst = 1;
            end else if (!m_active) begin
                if (req_valid) begin
                    m_active = 1; m_off = 1; m_after_rst = 0;
                    m_write = req_write; m_addr = req_addr; m_wdata = req_wdata;
                    m_decode(req_write, req_funct3, req_addr, m_mask, m_fault);
                    m_data = mmem[req_addr[11:2]];
                    if (req_write && !m_fault) mmem[req_addr[11:2]] = req_wdata;
                end
            end else if (m_fault || m_off == PH + 1) begin
                m_active = 0;
            end else begin
                m_off++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int t0, s_rd, s_wr, s_rv, s_st;

    task automatic snap();
        s_rd = rd_cnt; s_wr = wr_cnt; s_rv = rv_cnt; s_st = stall_cnt;
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
    endtask

    task automatic idle_req();
        req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7)); req_addr = $urandom; req_wdata = $urandom;
    endtask

    // One isolated op: request in cycle t0, then idle inputs, then settle.
    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        snap();
        @(posedge clk); #1; drive(w, f3, a, d); t0 = cyc;
        @(posedge clk); #1; idle_req();
        repeat (PH + 3) @(posedge clk);
        #1;
    endtask

    task automatic good_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                             input logic [3:0] mask, input logic [31:0] data);
        op(1'b0, f3, a, 32'h0);
        chk({nm, "_rdata"}, last_rdata, data);
        chk({nm, "_mask"}, 32'(last_mask), 32'(mask));
        chk({nm, "_latency"}, last_resp_cyc - t0, 3);
        chk({nm, "_reads"}, rd_cnt - s_rd, 2);
        chk({nm, "_writes"}, wr_cnt - s_wr, 0);
        chk({nm, "_fault"}, 32'(last_fault), 0);
    endtask

    task automatic bad_op(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a);
        op(w, f3, a, 32'h1234_5678);
        chk({nm, "_fault"}, 32'(last_fault), 1);
        chk({nm, "_latency"}, last_resp_cyc - t0, 1);
        chk({nm, "_strobes"}, (rd_cnt - s_rd) + (wr_cnt - s_wr), 0);
        chk({nm, "_resps"}, rv_cnt - s_rv, 1);
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] pm;
    logic       pf;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bmem[i] = $urandom; mmem[i] = bmem[i];
        end
        bmem[1] = 32'hDEAD_BEEF; mmem[1] = 32'hDEAD_BEEF;   // 0x1004
        bmem[0] = 32'h1122_3344; mmem[0] = 32'h1122_3344;   // 0x1000

        // pin the reference decode itself
        m_decode(1'b0, 3'b010, 32'h1004, pm, pf); chk("pin_lw", {27'd0, pf, pm}, {27'd0, 1'b0, 4'b1111});
        m_decode(1'b0, 3'b100, 32'h1003, pm, pf); chk("pin_lbu", {27'd0, pf, pm}, {27'd0, 1'b0, 4'b0001});
        m_decode(1'b0, 3'b001, 32'h1001, pm, pf); chk("pin_lh_mis", 32'(pf), 1);
        m_decode(1'b1, 3'b100, 32'h1000, pm, pf); chk("pin_st100", 32'(pf), 1);

        @(posedge clk); #1; check_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_strobes", {30'd0, mem_memread, mem_memwrite}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mask", 32'(mem_sign_mask), 0);
        chk("rst_rdata", resp_rdata, 0);
        @(posedge clk); #1; rst = 1'b0;

        snap();
        good_load("lw_1004", 3'b010, 32'h1004, 4'b1111, 32'hDEAD_BEEF);
        chk("lw_1004_stall_cycles", stall_cnt - s_st, 3);
        good_load("lbu_1003", 3'b100, 32'h1003, 4'b0001, 32'h1122_3344);
        good_load("lb_1003",  3'b000, 32'h1003, 4'b1001, 32'h1122_3344);
        good_load("lhu_1002", 3'b101, 32'h1002, 4'b0011, 32'h1122_3344);

        op(1'b1, 3'b010, 32'h2000, 32'h0000_00A5);
        chk("sw_led", 32'(led_q), 32'hA5);
        chk("sw_writes", wr_cnt - s_wr, 2);
        chk("sw_reads", rd_cnt - s_rd, 0);
        chk("sw_fault", 32'(last_fault), 0);
        chk("sw_mask", 32'(last_mask), 32'hF);

        bad_op("lw_mis",  1'b0, 3'b010, 32'h1002);
        bad_op("lh_mis",  1'b0, 3'b001, 32'h1001);
        bad_op("f3_011",  1'b0, 3'b011, 32'h1000);
        bad_op("st_f3_100", 1'b1, 3'b100, 32'h1000);

        // back-to-back LW / SW / LW with req_valid held high
        snap();
        @(posedge clk); #1; drive(1'b0, 3'b010, 32'h1004, 32'h0); t0 = cyc;
        repeat (4) @(posedge clk); #1; drive(1'b1, 3'b010, 32'h1100, 32'hCAFE_F00D);
        repeat (4) @(posedge clk); #1; drive(1'b0, 3'b010, 32'h1100, 32'h0);
        repeat (4) @(posedge clk); #1; idle_req();
        repeat (4) @(posedge clk); #1;
        chk("b2b_resps", rv_cnt - s_rv, 3);
        chk("b2b_last_cycle", last_resp_cyc - t0, 11);
        chk("b2b_rdata", last_rdata, 32'hCAFE_F00D);
        chk("b2b_reads", rd_cnt - s_rd, 4);
        chk("b2b_writes", wr_cnt - s_wr, 2);

        // reset during the second strobe cycle of a load
        snap();
        @(posedge clk); #1; drive(1'b0, 3'b010, 32'h1004, 32'h0); t0 = cyc;
        @(posedge clk); #1; idle_req();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("rstmid_resps", rv_cnt - s_rv, 0);
        chk("rstmid_reads", rd_cnt - s_rd, 2);
        good_load("lw_after_rst", 3'b010, 32'h1004, 4'b1111, 32'hDEAD_BEEF);

        // randomized traffic, including requests presented while busy
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) != 0)
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      32'($urandom_range(0, 4095)), $urandom);
            else
                idle_req();
        end
        @(posedge clk); #1; idle_req();
        repeat (8) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
